// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the unified-memory arbiter.
// Latency: none (declarations only). Backpressure: none (declarations only).
package mem_arbiter_pkg;

    // Owner of the read that is outstanding in the current cycle.
    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_IF_RD = 2'd1,
        ARB_D_RD  = 2'd2
    } arb_state_t;

    localparam logic [3:0] ARB_BE_ALL = 4'hF;
    localparam int         CONFLICT_W = 16;

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch, data, flush and memory-macro signals of the unified-memory arbiter.
// Latency: none (wiring). Backpressure: none (wiring).
// Optional MEM_ARB_STATS_EN adds the conflict_cnt_o statistics output.
interface mem_arbiter_if #(
    parameter int ADDR_W = 10
);
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_gnt_o;
    logic              if_stall_o;
    logic              if_rvalid_o;
    logic [31:0]       if_rdata_o;

    logic              d_req_i;
    logic              d_we_i;
    logic [ADDR_W-1:0] d_addr_i;
    logic [31:0]       d_wdata_i;
    logic [3:0]        d_be_i;
    logic              d_gnt_o;
    logic              d_rvalid_o;
    logic [31:0]       d_rdata_o;

    logic              flush_i;

    logic              mem_en_o;
    logic              mem_we_o;
    logic [3:0]        mem_be_o;
    logic [ADDR_W-3:0] mem_addr_o;
    logic [31:0]       mem_wdata_o;
    logic [31:0]       mem_rdata_i;
`ifdef MEM_ARB_STATS_EN
    logic [15:0]       conflict_cnt_o;
`endif

    // Arbiter side.
    modport slave (
`ifdef MEM_ARB_STATS_EN
        output conflict_cnt_o,
`endif
        input  if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i, d_be_i,
        input  flush_i, mem_rdata_i,
        output if_gnt_o, if_stall_o, if_rvalid_o, if_rdata_o,
        output d_gnt_o, d_rvalid_o, d_rdata_o,
        output mem_en_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
    );

    // Pipeline / memory side.
    modport master (
`ifdef MEM_ARB_STATS_EN
        input  conflict_cnt_o,
`endif
        output if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i, d_be_i,
        output flush_i, mem_rdata_i,
        input  if_gnt_o, if_stall_o, if_rvalid_o, if_rdata_o,
        input  d_gnt_o, d_rvalid_o, d_rdata_o,
        input  mem_en_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/mem_arbiter_sat_counter.sv
// Saturating up-counter with clear; clear wins over increment.
// Latency: count updates at the clock edge after inc/clr. Backpressure: none.
module mem_arbiter_sat_counter #(
    parameter int W   = 4,
    parameter int MAX = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);
    localparam logic [W-1:0] CNT_MAX = W'(MAX);

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + W'(1);
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-ported memory between fetch and data; data wins unless fetch has starved.
// Latency: grant is combinational, read data returns 1 cycle after grant. Backpressure: loser stalls, no queueing.
// Optional MEM_ARB_STATS_EN counts cycles where both ports request.
module mem_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int STARVE_MAX = 4
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    import mem_arbiter_pkg::*;

    arb_state_t  state;
    arb_state_t  state_nxt;
    logic        if_gnt;
    logic        d_gnt;
    logic        d_store;
    logic        flush_q;
    logic        starve_inc;
    logic        starve_full;
    logic [3:0]  starve_cnt;

    assign starve_full = (starve_cnt == 4'(STARVE_MAX));

    always_comb begin
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        state_nxt = ARB_IDLE;
        if (rst) begin
            if_gnt = bus.if_req_i & ~bus.flush_i & (~bus.d_req_i | starve_full);
            d_gnt  = bus.d_req_i & ~if_gnt;
        end
        // Every state has the same exits, so back-to-back reads need no bubble.
        if (if_gnt) begin
            state_nxt = ARB_IF_RD;
        end else if (d_gnt && !bus.d_we_i) begin
            state_nxt = ARB_D_RD;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ARB_IDLE;
            flush_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            flush_q <= bus.flush_i;
        end
    end

    assign d_store    = d_gnt & bus.d_we_i;
    assign starve_inc = bus.if_req_i & ~if_gnt;

    assign bus.if_gnt_o   = if_gnt;
    assign bus.d_gnt_o    = d_gnt;
    assign bus.if_stall_o = starve_inc;

    assign bus.mem_en_o    = if_gnt | d_gnt;
    assign bus.mem_we_o    = d_store;
    assign bus.mem_be_o    = d_store ? bus.d_be_i : ARB_BE_ALL;
    assign bus.mem_wdata_o = d_store ? bus.d_wdata_i : 32'h0;
    assign bus.mem_addr_o  = if_gnt ? bus.if_addr_i[ADDR_W-1:2] :
                             d_gnt  ? bus.d_addr_i[ADDR_W-1:2]  : '0;

    // A flush in either the grant or the response cycle kills the fetch reply.
    assign bus.if_rvalid_o = rst & (state == ARB_IF_RD) & ~bus.flush_i & ~flush_q;
    assign bus.d_rvalid_o  = rst & (state == ARB_D_RD);
    assign bus.if_rdata_o  = bus.if_rvalid_o ? bus.mem_rdata_i : 32'h0;
    assign bus.d_rdata_o   = bus.d_rvalid_o  ? bus.mem_rdata_i : 32'h0;

    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{bus.if_addr_i[1:0], bus.d_addr_i[1:0]};

    mem_arbiter_sat_counter #(
        .W   (4),
        .MAX (STARVE_MAX)
    ) u_starve_cnt (
        .clk (clk),
        .rst (rst),
        .inc (starve_inc),
        .clr (~starve_inc),
        .cnt (starve_cnt)
    );

`ifdef MEM_ARB_STATS_EN
    mem_arbiter_sat_counter #(
        .W   (CONFLICT_W),
        .MAX ((1 << CONFLICT_W) - 1)
    ) u_conflict_cnt (
        .clk (clk),
        .rst (rst),
        .inc (bus.if_req_i & bus.d_req_i),
        .clr (1'b0),
        .cnt (bus.conflict_cnt_o)
    );
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed plus randomized checking of mem_arbiter against a cycle-level behavioural model.
module tb_mem_arbiter;
    localparam int ADDR_W     = 10;
    localparam int STARVE_MAX = 4;
    localparam int WORDS      = 1 << (ADDR_W - 2);

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    mem_arbiter #(
        .ADDR_W     (ADDR_W),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Memory macro seen by the DUT, and an independent reference image.
    logic [31:0] macro_mem [WORDS];
    logic [31:0] ref_mem   [WORDS];

    always @(posedge clk) begin
        if (bus.mem_en_o) begin
            if (bus.mem_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (bus.mem_be_o[b])
                        macro_mem[bus.mem_addr_o][8*b +: 8] <= bus.mem_wdata_o[8*b +: 8];
            end else begin
                bus.mem_rdata_i <= macro_mem[bus.mem_addr_o];
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state.
    int          lost_run   = 0;  // consecutive cycles fetch asked and lost
    int          pend_kind  = 0;  // 0 none, 1 fetch read, 2 data read
    logic [31:0] pend_dat   = '0;
    logic        pend_flush = 1'b0;
    int          conf_m     = 0;
    int          fetch_wins = 0;
    logic        last_if_gnt = 1'b0;
    logic        last_d_gnt  = 1'b0;

    task automatic step(input logic r, input logic ir, input logic [ADDR_W-1:0] ia,
                        input logic dr, input logic dw, input logic [ADDR_W-1:0] da,
                        input logic [31:0] wd, input logic [3:0] be, input logic fl);
        logic fw, dwin, st, ifv, dv;
        @(negedge clk);
        rst           = r;
        bus.if_req_i  = ir;
        bus.if_addr_i = ia;
        bus.d_req_i   = dr;
        bus.d_we_i    = dw;
        bus.d_addr_i  = da;
        bus.d_wdata_i = wd;
        bus.d_be_i    = be;
        bus.flush_i   = fl;
        #1;
        fw   = r && ir && !fl && (!dr || lost_run >= STARVE_MAX);
        dwin = r && dr && !fw;
        st   = dwin && dw;
        ifv  = r && pend_kind == 1 && !pend_flush && !fl;
        dv   = r && pend_kind == 2;
        check("if_gnt",    32'(bus.if_gnt_o),    32'(fw));
        check("d_gnt",     32'(bus.d_gnt_o),     32'(dwin));
        check("if_stall",  32'(bus.if_stall_o),  32'(ir && !fw));
        check("mem_en",    32'(bus.mem_en_o),    32'(fw || dwin));
        check("mem_we",    32'(bus.mem_we_o),    32'(st));
        check("mem_be",    32'(bus.mem_be_o),    st ? 32'(be) : 32'hF);
        check("mem_wdata", bus.mem_wdata_o,      st ? wd : 32'h0);
        if (fw || dwin)
            check("mem_addr", 32'(bus.mem_addr_o), fw ? 32'(ia) >> 2 : 32'(da) >> 2);
        check("if_rvalid", 32'(bus.if_rvalid_o), 32'(ifv));
        check("if_rdata",  bus.if_rdata_o,       ifv ? pend_dat : 32'h0);
        check("d_rvalid",  32'(bus.d_rvalid_o),  32'(dv));
        check("d_rdata",   bus.d_rdata_o,        dv ? pend_dat : 32'h0);
`ifdef MEM_ARB_STATS_EN
        check("conflict_cnt", 32'(bus.conflict_cnt_o), 32'(conf_m));
`endif
        @(posedge clk);
        last_if_gnt = fw;
        last_d_gnt  = dwin;
        if (!r) begin
            lost_run   = 0;
            pend_kind  = 0;
            pend_flush = 1'b0;
            conf_m     = 0;
        end else begin
            lost_run  = (ir && !fw) ? ((lost_run < STARVE_MAX) ? lost_run + 1 : STARVE_MAX) : 0;
            pend_kind = fw ? 1 : (dwin && !dw) ? 2 : 0;
            if (fw)
                pend_dat = ref_mem[32'(ia) >> 2];
            else if (dwin && !dw)
                pend_dat = ref_mem[32'(da) >> 2];
            if (st)
                for (int b = 0; b < 4; b++)
                    if (be[b]) ref_mem[32'(da) >> 2][8*b +: 8] = wd[8*b +: 8];
            pend_flush = fl;
            if (ir && dr && conf_m < 65535) conf_m++;
            if (fw) fetch_wins++;
        end
    endtask

    task automatic idle();
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 32'h0, 4'h0, 1'b0);
    endtask

    logic              r_ir, r_dr, r_dw, r_fl, r_rst;
    logic [ADDR_W-1:0] r_ia, r_da;
    logic [31:0]       r_wd;
    logic [3:0]        r_be;

    initial begin
        for (int i = 0; i < WORDS; i++) begin
            macro_mem[i] = $urandom;
            ref_mem[i]   = macro_mem[i];
        end

        // Reset held with both requesters active.
        repeat (3) step(1'b0, 1'b1, 10'h010, 1'b1, 1'b0, 10'h020, 32'h0, 4'h0, 1'b0);

        // Lone fetch, then its response.
        step(1'b1, 1'b1, 10'h010, 1'b0, 1'b0, '0, 32'h0, 4'h0, 1'b0);
        idle();

        // Conflict on a load: data wins, fetch stalls.
        step(1'b1, 1'b1, 10'h010, 1'b1, 1'b0, 10'h020, 32'h0, 4'h0, 1'b0);
        idle();

        // Continuous conflict: fetch should win every fifth cycle.
        fetch_wins = 0;
        repeat (15) step(1'b1, 1'b1, 10'h040, 1'b1, 1'b0, 10'h080, 32'h0, 4'h0, 1'b0);
        check("starve_wins", 32'(fetch_wins), 32'd3);
        idle();

        // Partial store, then a load of the same word.
        step(1'b1, 1'b0, '0, 1'b1, 1'b1, 10'h008, 32'hAABBCCDD, 4'b0011, 1'b0);
        step(1'b1, 1'b0, '0, 1'b1, 1'b0, 10'h008, 32'h0, 4'h0, 1'b0);
        idle();
        check("store_half", bus.mem_rdata_i & 32'h0000FFFF, 32'h0000CCDD);

        // Flush in the response cycle, then flush against a lone fetch.
        step(1'b1, 1'b1, 10'h100, 1'b0, 1'b0, '0, 32'h0, 4'h0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 32'h0, 4'h0, 1'b1);
        step(1'b1, 1'b1, 10'h104, 1'b0, 1'b0, '0, 32'h0, 4'h0, 1'b1);
        idle();

`ifdef MEM_ARB_STATS_EN
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 32'h0, 4'h0, 1'b0);
        repeat (7) step(1'b1, 1'b1, 10'h010, 1'b1, 1'b0, 10'h020, 32'h0, 4'h0, 1'b0);
        @(negedge clk);
        check("conflict7", 32'(bus.conflict_cnt_o), 32'd7);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 32'h0, 4'h0, 1'b0);
        @(negedge clk);
        check("conflict_rst", 32'(bus.conflict_cnt_o), 32'd0);
`endif

        // Randomized traffic; requesters hold until granted.
        r_ir = 1'b0; r_dr = 1'b0; r_dw = 1'b0;
        r_ia = '0; r_da = '0; r_wd = '0; r_be = '0;
        last_if_gnt = 1'b1; last_d_gnt = 1'b1;
        for (int n = 0; n < 800; n++) begin
            if (!r_ir || last_if_gnt) begin
                r_ir = ($urandom_range(0, 3) != 0);
                r_ia = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
            end
            if (!r_dr || last_d_gnt) begin
                r_dr = ($urandom_range(0, 2) != 0);
                r_dw = $urandom_range(0, 1) == 1;
                r_da = ADDR_W'($urandom_range(0, 63));
                r_wd = $urandom;
                r_be = 4'($urandom_range(0, 15));
            end
            r_fl  = ($urandom_range(0, 5) == 0);
            r_rst = ($urandom_range(0, 59) != 0);
            step(r_rst, r_ir, r_ia, r_dr, r_dw, r_da, r_wd, r_be, r_fl);
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported synchronous unified memory between the instruction-fetch port (IF stage) and the data port (MEM stage) of the 5-stage pipeline.
- Per cycle, grants at most one requester.
- Returns read data one cycle after the grant.
- Drives a fetch stall when fetch loses arbitration.
- Bounds fetch starvation with a saturating counter.
- Sits between the pipeline registers and the memory macro, replacing separate instruction and data memories.

Parameters:
- ADDR_W, 10, byte-address width. The memory word address is addr[ADDR_W-1:2].
- STARVE_MAX, 4, number of consecutive lost fetch cycles after which fetch wins once. Legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- if_req_i  in  1  fetch read request.
- if_addr_i  in  ADDR_W  fetch byte address.
- if_gnt_o  out  1  fetch granted this cycle (combinational).
- if_stall_o  out  1  if_req_i & ~if_gnt_o; freezes PC and IF/ID.
- if_rvalid_o  out  1  fetch read data valid.
- if_rdata_o  out  32  fetch read data; 0 when if_rvalid_o=0.
- d_req_i  in  1  data request.
- d_we_i  in  1  1=store, 0=load.
- d_addr_i  in  ADDR_W  data byte address.
- d_wdata_i  in  32  store data, already lane-aligned.
- d_be_i  in  4  store byte enables.
- d_gnt_o  out  1  data granted this cycle (combinational).
- d_rvalid_o  out  1  load data valid.
- d_rdata_o  out  32  load data; 0 when d_rvalid_o=0.
- flush_i  in  1  pipeline flush from taken branch or jump.
- mem_en_o  out  1  memory access enable.
- mem_we_o  out  1  memory write enable.
- mem_be_o  out  4  memory byte enables.
- mem_addr_o  out  ADDR_W-2  memory word address.
- mem_wdata_o  out  32  memory write data.
- mem_rdata_i  in  32  memory read data, valid one cycle after a read enable.

Behaviour:
- Reset (rst=0 at a clock edge):
  - state=IDLE, starve_cnt=0.
  - While rst=0, all gnt, rvalid and mem_en/mem_we outputs are forced to 0, and rdata outputs are 0.
- Arbitration (combinational from requests and registered starve_cnt):
  - Only d_req: data granted.
  - Only if_req (and flush_i=0): fetch granted.
  - Both, starve_cnt<STARVE_MAX: data granted.
  - Both, starve_cnt==STARVE_MAX: fetch granted.
  - flush_i=1 blocks any new fetch grant that cycle; data is unaffected.
- Memory drive:
  - mem_en_o = any grant.
  - mem_we_o = d_gnt_o & d_we_i.
  - mem_be_o = d_be_i on a data store, 4'hF otherwise.
  - Address and wdata are muxed from the granted port. mem_wdata_o=0 when not storing.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) when if_req_i=1 and if_gnt_o=0.
  - Clears when if_gnt_o=1 or if_req_i=0.
- FSM (tracks the owner of the outstanding read; next state from the current grant):
  - IDLE -> IF_RD on fetch grant.
  - IDLE -> D_RD on data load grant.
  - IDLE -> IDLE on data store or no grant.
  - The same transitions apply from IF_RD and D_RD (back-to-back grants, no bubble).
- Responses:
  - if_rvalid_o = (state==IF_RD) & ~flush_i & ~flush_q, where flush_q is flush_i registered at the grant cycle. A flush in the grant cycle or the response cycle discards the fetch data.
  - d_rvalid_o = (state==D_RD).
  - Stores produce no rvalid; they complete at the grant edge.
  - Read latency: exactly 1 cycle from grant to rvalid.
- Requesters hold req/addr stable until they see a grant. The arbiter does not queue requests.
- Reset mid-operation: a pending rvalid is dropped; there is no response after reset release.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- Defined:
  - Adds output port conflict_cnt_o [15:0]: the number of cycles with if_req_i & d_req_i.
  - Saturates at 16'hFFFF.
  - Reset to 0.
- Undefined: the port and its counter are absent. All other behaviour is identical.

Decomposition:
- Add to defines.v:
  - FSM encodings `ARB_IDLE=2'd0, `ARB_IF_RD=2'd1, `ARB_D_RD=2'd2.
  - `ARB_BE_ALL=4'hF.
- One sub-module is natural: sat_counter (parameterised width and max, with inc/clr and a synchronous active-low reset). It is used for starve_cnt and conflict_cnt_o.

Test Plan:
- Reset held 3 cycles with both reqs=1 -> all gnt, rvalid and mem_en=0. After release, if_req only at addr 0x010 -> if_gnt=1, mem_addr=0x004; next cycle if_rvalid=1, if_rdata=mem[4].
- Both reqs, d_we=0, d_addr=0x020 -> d_gnt=1, if_stall=1. Next cycle d_rvalid=1 with mem[8]; if_rvalid=0.
- Both reqs held continuously, STARVE_MAX=4 -> data wins 4 cycles, fetch wins cycle 5, pattern repeats; if_stall low only in every 5th cycle.
- Store d_addr=0x08, d_be=4'b0011, wdata=0xAABBCCDD -> mem_we=1, mem_be=0011; no d_rvalid; later load returns the lower halfword updated.
- Fetch granted with flush_i pulsed in the response cycle -> if_rvalid=0. flush_i with only if_req -> if_gnt=0, mem_en=0.
- MEM_ARB_STATS_EN defined: 7 conflict cycles -> conflict_cnt_o=7; reset clears it to 0.
